// File: rtl/conv_window_gen_pkg.sv
// conv_pkg: shared types and default dimensions for the 3x3 convolution
// datapath (window generator and FP16 kernel).
//   fp16_t    - opaque FP16 bit pattern
//   win3x3_t  - 9-lane window, index = 3*r + c (0 = top-left)
//   win_idx() - maps (row, col) of the window to its lane index
package conv_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [8:0] win3x3_t;

    localparam int unsigned IMG_W_DEF  = 28;
    localparam int unsigned IMG_H_DEF  = 28;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned WIN_TAPS   = 9;

    function automatic logic [3:0] win_idx(input int unsigned r, input int unsigned c);
        return 4'(3 * r + c);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in, 3x3 window stream out.
//   in_valid/in_data     - raster-order pixel stream (no backpressure)
//   out_valid/out_window - window strobe and 9-lane window (index 3*r + c)
//   frame_done           - pulse with the last window of a frame
// master = pixel source / window sink, slave = window generator.
interface conv_window_gen_if
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                               in_valid;
    logic [DATA_W-1:0]                  in_data;
    logic                               out_valid;
    logic [WIN_TAPS-1:0][DATA_W-1:0]    out_window;
    logic                               frame_done;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_window,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_window,
        output frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buf.sv
// conv_line_buf: row delay of depth DEPTH, read-before-write at one address.
//   clk   - clock
//   we    - write enable
//   addr  - column address (read and write share it)
//   wdata - value stored at addr on the rising edge
//   rdata - current contents at addr (combinational, i.e. the old value)
// Storage is not reset: every entry is rewritten before it is consumed.
module conv_line_buf #(
    parameter int unsigned DEPTH = 28,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 sliding-window generator (stride 1, no pad).
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clear - synchronous frame restart; same-cycle pixel becomes (0,0)
//   bus   - slave side of conv_window_gen_if (pixel in, window out)
// The two previous rows live in one line buffer of width 2*DATA_W holding
// {row y-1, row y-2} per column, so a single read/write per pixel moves
// both rows down by one.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    conv_window_gen_if.slave   bus
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]                   col, col_eff;
    logic [RW-1:0]                   row, row_eff;
    logic                            last_col, last_row;
    logic [2*DATA_W-1:0]             lb_rd, lb_wr;
    logic [DATA_W-1:0]               rd_old, rd_new;
    logic [2:0][DATA_W-1:0]          new_col;
    logic [WIN_TAPS-1:0][DATA_W-1:0] win;
    logic                            valid_q, done_q;

    // clear takes effect before the same-cycle pixel is placed
    always_comb begin
        col_eff    = clear ? '0 : col;
        row_eff    = clear ? '0 : row;
        last_col   = (col_eff == CW'(IMG_W - 1));
        last_row   = (row_eff == RW'(IMG_H - 1));
        rd_old     = lb_rd[DATA_W-1:0];
        rd_new     = lb_rd[2*DATA_W-1:DATA_W];
        lb_wr      = {bus.in_data, rd_new};
        new_col[0] = rd_old;
        new_col[1] = rd_new;
        new_col[2] = bus.in_data;
    end

    conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (2 * DATA_W),
        .AW    (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (bus.in_valid),
        .addr  (col_eff),
        .wdata (lb_wr),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            win     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            col     <= col_eff;
            row     <= row_eff;
            if (bus.in_valid) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    for (int unsigned c = 0; c < 2; c++) begin
                        win[win_idx(r, c)] <= win[win_idx(r, c + 1)];
                    end
                    win[win_idx(r, 2)] <= new_col[r];
                end
                valid_q <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
                done_q  <= last_row && last_col;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row_eff + RW'(1);
                end else begin
                    col <= col_eff + CW'(1);
                end
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_window = win;
    assign bus.frame_done = done_q;

endmodule
